// File: rtl/axis_out_stage.sv
// AXI-Stream output stage: pops lane entries from the resizing buffer, drops null beats, masks lanes past tlast.
// Optional statistics (beat_cnt, pkt_cnt, pkt_open) are enabled with `define AXIS_OUT_STATS_EN.
module axis_out_stage #(
  parameter int T_DATA_WIDTH     = 1,
  parameter int M_KEEP_WIDTH     = 2,
  parameter int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH,
  parameter int SKID_DEPTH       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BUF_OUT_ENTRY_SZ-1:0]          buf_entry,
  input  logic                                 buf_underflow,
  output logic                                 buf_ready,
  output logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready
`ifdef AXIS_OUT_STATS_EN
  ,
  output logic [31:0]                          beat_cnt,
  output logic [31:0]                          pkt_cnt,
  output logic                                 pkt_open
`endif
);

  localparam int LANE_W = 2 + T_DATA_WIDTH;
  localparam int DATA_W = T_DATA_WIDTH * M_KEEP_WIDTH;
  localparam int BEAT_W = DATA_W + M_KEEP_WIDTH + 1;
  localparam int PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W + 1)'(SKID_DEPTH);

  typedef enum logic {
    IDLE,
    IN_PKT
  } pkt_state_e;

  logic                        rst_q;
  logic                        inflight_q;
  logic                        pend_q;
  logic [BUF_OUT_ENTRY_SZ-1:0] entry_q;
  logic [BEAT_W-1:0]           mem [SKID_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [CNT_W-1:0]            count_q;
  pkt_state_e                  state_q;
  pkt_state_e                  state_d;

  logic [DATA_W-1:0]           lane_data;
  logic [M_KEEP_WIDTH-1:0]     lane_keep;
  logic [M_KEEP_WIDTH-1:0]     lane_last;
  logic [M_KEEP_WIDTH-1:0]     masked_keep;
  logic                        seen_last;
  logic                        is_null;
  logic                        wr_en;
  logic                        rd_en;
  logic                        pop;
  logic [CNT_W:0]              occupancy;
  logic [BEAT_W-1:0]           beat_in;
  logic [BEAT_W-1:0]           head;

  // Every slot that may still land in the FIFO is reserved before popping, so
  // a captured entry always has room even if tready stays low forever.
  always_comb begin
    occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) + (CNT_W + 1)'(pend_q);
    buf_ready = !rst_q && (occupancy < DEPTH_CNT);
    pop       = buf_ready && !buf_underflow;
  end

  // Lane decode and mask of the captured entry.
  always_comb begin
    lane_data   = '0;
    lane_keep   = '0;
    lane_last   = '0;
    masked_keep = '0;
    seen_last   = 1'b0;
    for (int i = 0; i < M_KEEP_WIDTH; i++) begin
      lane_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = entry_q[LANE_W*i +: T_DATA_WIDTH];
      lane_keep[i] = entry_q[LANE_W*i + T_DATA_WIDTH];
      lane_last[i] = entry_q[LANE_W*i + T_DATA_WIDTH + 1];
    end
    // NOTE: seen_last is a blocking scratch variable carried across loop
    // iterations; that ordering is exactly what blocking assignment gives in
    // combinational logic, and it is never used outside this block.
    for (int i = 0; i < M_KEEP_WIDTH; i++) begin
      masked_keep[i] = lane_keep[i] && !seen_last;
      if (lane_last[i]) seen_last = 1'b1;
    end
  end

  assign is_null = !(|lane_keep) && !(|lane_last);
  assign wr_en   = pend_q && !is_null;
  assign beat_in = {|lane_last, masked_keep, lane_data};
  assign rd_en   = m_axis_tvalid && m_axis_tready;

  // Pop pipeline: inflight marks the cycle the buffer is producing data,
  // pend marks the captured entry waiting to be filtered into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      inflight_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      rst_q      <= 1'b0;
      inflight_q <= pop;
      pend_q     <= inflight_q;
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_q) entry_q <= buf_entry;
  end

  // NOTE: the storage array is deliberately not reset; the outputs below are
  // qualified by a non-empty FIFO, so stale contents can never be observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= beat_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign head          = mem[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);

  always_comb begin
    {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = '0;
    if (m_axis_tvalid) {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head;
  end

  // Packet tracker, advanced only on emitted beats.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rd_en) begin
      unique case (state_q)
        IDLE:    state_d = m_axis_tlast ? IDLE : IN_PKT;
        IN_PKT:  state_d = m_axis_tlast ? IDLE : IN_PKT;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef AXIS_OUT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (rd_en) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (m_axis_tlast) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  assign pkt_open = (state_q == IN_PKT);
`else
  // Statistics disabled: no counters and no extra ports; the tracker above
  // is kept so both builds share one data path.
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !rd_en && (count_q == DEPTH_CNT[CNT_W-1:0])));

endmodule

// File: tb/tb_axis_out_stage.sv
// Scoreboard bench for axis_out_stage: a buffer model feeds entries, a lane-rule model predicts beats,
// and an independent monitor compares every accepted beat.
module tb_axis_out_stage;

  localparam int TW  = 1;
  localparam int MK  = 2;
  localparam int LW  = 2 + TW;
  localparam int ESZ = LW * MK;
  localparam int D   = 2;
  localparam int BW  = TW * MK + MK + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [ESZ-1:0] buf_entry;
  logic           buf_underflow;
  logic           buf_ready;
  logic [TW*MK-1:0] tdata;
  logic [MK-1:0]  tkeep;
  logic           tlast;
  logic           tvalid;
  logic           tready;
`ifdef AXIS_OUT_STATS_EN
  logic [31:0]    beat_cnt;
  logic [31:0]    pkt_cnt;
  logic           pkt_open;
`endif

  axis_out_stage #(
    .T_DATA_WIDTH(TW),
    .M_KEEP_WIDTH(MK),
    .SKID_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buf_entry(buf_entry),
    .buf_underflow(buf_underflow),
    .buf_ready(buf_ready),
    .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep),
    .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
`ifdef AXIS_OUT_STATS_EN
    ,
    .beat_cnt(beat_cnt),
    .pkt_cnt(pkt_cnt),
    .pkt_open(pkt_open)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [ESZ-1:0] src_q[$];
  logic [BW-1:0]  exp_q[$];
  bit  src_en    = 1'b0;
  bit  stall_en  = 1'b0;
  int  ready_pct = 100;
  int  cyc       = 0;
  int  pop_cnt   = 0;
  int  beat_seen = 0;
  int  first_pop_cyc = 0;
  int  first_tv_cyc  = 0;
  int  model_beats = 0;
  int  model_pkts  = 0;
  bit  model_open  = 1'b0;

  function automatic logic [LW-1:0] ln(input bit last, input bit keep, input logic [TW-1:0] d);
    return {last, keep, d};
  endfunction

  // Reference: the first lane carrying last ends the beat; entries with
  // neither keep nor last produce no beat at all.
  function automatic void model_push(input logic [ESZ-1:0] e);
    int k;
    bit any_keep;
    logic [MK-1:0]    kp;
    logic [TW*MK-1:0] d;
    k = MK;
    any_keep = 1'b0;
    for (int i = MK - 1; i >= 0; i--)
      if (e[LW*i + TW + 1]) k = i;
    for (int i = 0; i < MK; i++) begin
      d[i*TW +: TW] = e[LW*i +: TW];
      kp[i] = e[LW*i + TW] && (i <= k);
      any_keep |= e[LW*i + TW];
    end
    src_q.push_back(e);
    if (k == MK && !any_keep) return;
    exp_q.push_back({k < MK, kp, d});
    model_beats++;
    if (k < MK) model_pkts++;
    model_open = (k == MK);
  endfunction

  function automatic logic [ESZ-1:0] rand_entry();
    logic [ESZ-1:0] e;
    e = '0;
    if ($urandom_range(0, 6) == 0) return e;
    for (int i = 0; i < MK; i++)
      e[LW*i +: LW] = ln($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, TW'($urandom));
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Buffer model: a pop decided before edge N presents its entry after edge N.
  initial begin
    bit did;
    buf_entry     = '0;
    buf_underflow = 1'b1;
    tready        = 1'b0;
    forever begin
      @(negedge clk);
      did = buf_ready && !buf_underflow && !rst;
      if (did) begin
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (did && src_q.size() > 0) buf_entry = src_q.pop_front();
      else                         buf_entry = ESZ'($urandom);
      buf_underflow = !src_en || (src_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
      tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: compares every accepted beat and checks hold stability.
  logic [BW-1:0] cur;
  logic [BW-1:0] held;
  bit            stalled = 1'b0;
  assign cur = {tlast, tkeep, tdata};

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", tvalid, 1);
        check("hold_beat", cur, held);
      end
      if (tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (tvalid && tready) begin
        beat_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", cur);
        end else begin
          check("beat", cur, exp_q.pop_front());
        end
      end
      stalled = tvalid && !tready;
      held    = cur;
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size() + src_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int b0;
    int p0;
    logic [ESZ-1:0] e;
    #900000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    int p0;
    logic [ESZ-1:0] e;
    rst = 1'b1;

    // Reset with an empty buffer.
    repeat (10) begin
      @(negedge clk);
      check("rst_tvalid", tvalid, 0);
      check("rst_buf_ready", buf_ready, 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("underflow_tvalid", tvalid, 0);
    end

    // Two-entry packet, latency from first pop.
    ready_pct = 100;
    first_pop_cyc = -1;
    first_tv_cyc  = -1;
    model_push({ln(0, 1, 0), ln(0, 1, 1)});
    model_push({ln(0, 1, 0), ln(1, 1, 1)});
    src_en = 1'b1;
    drain("pkt2", 100);
    check("latency", first_tv_cyc - first_pop_cyc, 3);

    // Null entry between two valid entries.
    b0 = beat_seen;
    model_push({ln(0, 0, 0), ln(0, 1, 1)});
    model_push('0);
    model_push({ln(1, 1, 0), ln(0, 1, 1)});
    drain("null", 100);
    check("null_beats", beat_seen - b0, 2);

    // Sink stalled: stage fills to depth and stops popping.
    ready_pct = 0;
    @(negedge clk);
    @(negedge clk);
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++)
      model_push({ln(i == 3, 1, TW'($urandom)), ln(0, 1, TW'($urandom))});
    repeat (8) @(negedge clk);
    check("full_pops", pop_cnt - p0, D);
    check("full_buf_ready", buf_ready, 0);
    check("full_tvalid", tvalid, 1);
    ready_pct = 100;
    drain("full", 200);

    // Reset mid-packet with beats queued.
    model_push({ln(0, 1, 1), ln(0, 1, 0)});
    drain("open", 100);
`ifdef AXIS_OUT_STATS_EN
    check("pkt_open_before_rst", pkt_open, model_open);
`endif
    ready_pct = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) model_push({ln(0, 1, 0), ln(0, 1, 1)});
    repeat (8) @(negedge clk);
    check("queued_tvalid", tvalid, 1);
    rst = 1'b1;
    src_en = 1'b0;
    src_q.delete();
    exp_q.delete();
    model_beats = 0;
    model_pkts  = 0;
    model_open  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_buf_ready", buf_ready, 0);
`ifdef AXIS_OUT_STATS_EN
    check("midrst_pkt_open", pkt_open, 0);
    check("midrst_beat_cnt", beat_cnt, 0);
`endif
    ready_pct = 100;
    b0 = beat_seen;
    repeat (10) @(negedge clk);
    check("no_stale_beats", beat_seen - b0, 0);
    src_en = 1'b1;

    // Three 4-beat packets with random backpressure and buffer gaps.
    ready_pct = 60;
    stall_en  = 1'b1;
    b0 = beat_seen;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++)
        model_push({ln(b == 3, 1, TW'($urandom)), ln(0, 1, TW'($urandom))});
    drain("pkts", 1000);
    check("pkts_beats", beat_seen - b0, model_beats);
`ifdef AXIS_OUT_STATS_EN
    check("beat_cnt", beat_cnt, model_beats);
    check("pkt_cnt", pkt_cnt, model_pkts);
    check("pkt_open_end", pkt_open, model_open);
`endif

    // Random traffic.
    ready_pct = 70;
    for (int i = 0; i < 300; i++) begin
      e = rand_entry();
      model_push(e);
    end
    drain("random", 6000);
`ifdef AXIS_OUT_STATS_EN
    check("rand_beat_cnt", beat_cnt, model_beats);
    check("rand_pkt_cnt", pkt_cnt, model_pkts);
    check("rand_pkt_open", pkt_open, model_open);
`endif
    check("rand_tvalid_idle", tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
